out_packet_arbiter: RTL and testbench

Schedules the three packet sources of the monitor-bound return channel (power-on reply, keyboard/mouse event, microphone sample) onto the single 40-bit outbound packet slot of the serial sender. Sits between the packet sources and the sender in the mon_clk domain. It grants one source at a time, holds the packet stable until the sender takes it, and acknowledges the source. A stalled sender is bounded by a timeout with drop accounting.

---
 rtl/out_packet_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_out_packet_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_packet_arbiter.sv
// Return-channel packet arbiter: grants power, keyboard or mic onto the single
// outbound 40-bit slot, holds it until the sender takes it, and drops on a stall.
module out_packet_arbiter #(
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic        mon_clk,
    input  logic        reset,
    input  logic        power_req,
    input  logic [39:0] power_data,
    output logic        power_ack,
    input  logic        kb_req,
    input  logic [39:0] kb_data,
    output logic        kb_ack,
    input  logic        mic_req,
    input  logic [39:0] mic_data,
    output logic        mic_ack,
    output logic [39:0] out_data,
    output logic        out_valid,
    input  logic        out_taken,
    output logic [1:0]  grant_id,
    output logic [7:0]  drop_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0]    GID_NONE   = 2'd0;
    localparam logic [1:0]    GID_POWER  = 2'd1;
    localparam logic [1:0]    GID_KB     = 2'd2;
    localparam logic [1:0]    GID_MIC    = 2'd3;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        r_state;
    logic [39:0]   r_out_data;
    logic          r_out_valid;
    logic [1:0]    r_grant_id;
    logic [TW-1:0] r_timer;
    logic          r_rr;
    logic [7:0]    r_drop_count;
    logic [2:0]    r_ack;
    logic          r_busy;

    state_t        w_state_next;
    logic [39:0]   w_out_data_next;
    logic          w_out_valid_next;
    logic [1:0]    w_grant_id_next;
    logic [TW-1:0] w_timer_next;
    logic          w_rr_next;
    logic [7:0]    w_drop_count_next;
    logic [2:0]    w_ack_next;
    logic [1:0]    w_win_id;
    logic [39:0]   w_win_data;
    logic          w_timeout;
    logic [2:0]    w_owner_ack;
    logic          w_owner_rr;

    // Winner selection: power first, then the round-robin pointer decides kb vs mic.
    always_comb begin
        w_win_id = GID_NONE;
        if (power_req) begin
            w_win_id = GID_POWER;
        end else if (kb_req && mic_req) begin
            w_win_id = r_rr ? GID_MIC : GID_KB;
        end else if (kb_req) begin
            w_win_id = GID_KB;
        end else if (mic_req) begin
            w_win_id = GID_MIC;
        end else begin
            w_win_id = GID_NONE;
        end
    end

    // Packet mux for the selected winner.
    always_comb begin
        w_win_data = 40'd0;
        case (w_win_id)
            GID_POWER: w_win_data = power_data;
            GID_KB:    w_win_data = kb_data;
            GID_MIC:   w_win_data = mic_data;
            default:   w_win_data = 40'd0;
        endcase
    end

    // Ack line and round-robin update belonging to the current owner.
    always_comb begin
        w_owner_ack = 3'b000;
        w_owner_rr  = r_rr;
        case (r_grant_id)
            GID_POWER: w_owner_ack = 3'b001;
            GID_KB: begin
                w_owner_ack = 3'b010;
                w_owner_rr  = 1'b1;
            end
            GID_MIC: begin
                w_owner_ack = 3'b100;
                w_owner_rr  = 1'b0;
            end
            default: begin
                w_owner_ack = 3'b000;
                w_owner_rr  = r_rr;
            end
        endcase
    end

    assign w_timeout = (r_timer == TIMER_LAST);

    // Next-state and next-output logic; a take in the timeout cycle beats the drop.
    always_comb begin
        w_state_next      = r_state;
        w_out_data_next   = r_out_data;
        w_out_valid_next  = r_out_valid;
        w_grant_id_next   = r_grant_id;
        w_timer_next      = r_timer;
        w_rr_next         = r_rr;
        w_drop_count_next = r_drop_count;
        w_ack_next        = 3'b000;
        case (r_state)
            ST_IDLE: begin
                if (w_win_id != GID_NONE) begin
                    w_out_data_next  = w_win_data;
                    w_out_valid_next = 1'b1;
                    w_grant_id_next  = w_win_id;
                    w_timer_next     = {TW{1'b0}};
                    w_state_next     = ST_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (out_taken || w_timeout) begin
                    w_out_valid_next = 1'b0;
                    w_ack_next       = w_owner_ack;
                    w_rr_next        = w_owner_rr;
                    w_state_next     = ST_HOLD;
                    if (!out_taken && (r_drop_count != 8'hFF)) begin
                        w_drop_count_next = r_drop_count + 8'd1;
                    end else begin
                        w_drop_count_next = r_drop_count;
                    end
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            ST_HOLD: begin
                w_grant_id_next = GID_NONE;
                w_state_next    = ST_IDLE;
            end
            default: begin
                w_out_valid_next = 1'b0;
                w_grant_id_next  = GID_NONE;
                w_state_next     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_out_data   <= 40'd0;
            r_out_valid  <= 1'b0;
            r_grant_id   <= GID_NONE;
            r_timer      <= {TW{1'b0}};
            r_rr         <= 1'b0;
            r_drop_count <= 8'd0;
            r_ack        <= 3'b000;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_out_data   <= w_out_data_next;
            r_out_valid  <= w_out_valid_next;
            r_grant_id   <= w_grant_id_next;
            r_timer      <= w_timer_next;
            r_rr         <= w_rr_next;
            r_drop_count <= w_drop_count_next;
            r_ack        <= w_ack_next;
            r_busy       <= (w_state_next != ST_IDLE);
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign grant_id   = r_grant_id;
    assign drop_count = r_drop_count;
    assign busy       = r_busy;
    assign power_ack  = r_ack[0];
    assign kb_ack     = r_ack[1];
    assign mic_ack    = r_ack[2];

endmodule

// File: tb/tb_out_packet_arbiter.sv
// Bench for out_packet_arbiter: directed table, hand sequences for the timing
// corners, and a randomized run against a transaction-level reference model.
module tb_out_packet_arbiter;

    localparam int TO = 16;
    localparam logic [39:0] P_DATA = 40'hA0_0000_0001;
    localparam logic [39:0] K_DATA = 40'h12_3456_789A;
    localparam logic [39:0] M_DATA = 40'hC3_C3C3_C3C3;

    logic        mon_clk;
    logic        reset;
    logic        power_req, kb_req, mic_req, out_taken;
    logic [39:0] power_data, kb_data, mic_data;
    logic        power_ack, kb_ack, mic_ack, out_valid, busy;
    logic [39:0] out_data;
    logic [1:0]  grant_id;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    out_packet_arbiter #(.TIMEOUT(TO), .TW(13)) dut (
        .mon_clk(mon_clk), .reset(reset),
        .power_req(power_req), .power_data(power_data), .power_ack(power_ack),
        .kb_req(kb_req), .kb_data(kb_data), .kb_ack(kb_ack),
        .mic_req(mic_req), .mic_data(mic_data), .mic_ack(mic_ack),
        .out_data(out_data), .out_valid(out_valid), .out_taken(out_taken),
        .grant_id(grant_id), .drop_count(drop_count), .busy(busy)
    );

    initial mon_clk = 1'b0;
    always #5 mon_clk = ~mon_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a packet is either presented (with its age), in its
    // post-ack dead cycle, or absent; the source that last won kb/mic yields next.
    bit          m_presenting, m_hold, m_pref_mic;
    int          m_owner, m_age, m_drops, m_ack;
    logic [39:0] m_data;

    task automatic model_step();
        m_ack = 0;
        if (reset) begin
            m_presenting = 0; m_hold = 0; m_pref_mic = 0;
            m_owner = 0; m_age = 0; m_drops = 0; m_data = 40'd0;
        end else if (m_presenting) begin
            if (out_taken || m_age == TO - 1) begin
                m_ack = m_owner;
                if (!out_taken && m_drops < 255) m_drops++;
                if (m_owner == 2) m_pref_mic = 1;
                else if (m_owner == 3) m_pref_mic = 0;
                m_presenting = 0;
                m_hold = 1;
            end else begin
                m_age++;
            end
        end else if (m_hold) begin
            m_hold = 0;
            m_owner = 0;
        end else if (power_req || kb_req || mic_req) begin
            if (power_req) m_owner = 1;
            else if (kb_req && mic_req) m_owner = m_pref_mic ? 3 : 2;
            else if (kb_req) m_owner = 2;
            else m_owner = 3;
            m_data = (m_owner == 1) ? power_data : (m_owner == 2) ? kb_data : mic_data;
            m_presenting = 1;
            m_age = 0;
        end
    endtask

    task automatic tick();
        logic [54:0] act, exp;
        logic [2:0]  exp_ack;
        @(posedge mon_clk);
        model_step();
        @(negedge mon_clk);
        exp_ack = (m_ack == 1) ? 3'b001 : (m_ack == 2) ? 3'b010 : (m_ack == 3) ? 3'b100 : 3'b000;
        act = {out_valid, grant_id, mic_ack, kb_ack, power_ack, busy, drop_count, out_data};
        exp = {1'(m_presenting), 2'(m_owner), exp_ack, 1'(m_presenting || m_hold), 8'(m_drops), m_data};
        chk("model", 64'(act), 64'(exp));
    endtask

    typedef struct {
        logic        p, k, m, t;
        logic        v;
        logic [1:0]  gid;
        logic        gid_dc;
        logic [2:0]  ack;
        logic        busy;
        logic [39:0] data;
    } vec_t;

    function automatic vec_t mkv(logic p, logic k, logic m, logic t, logic v, logic [1:0] gid,
                                 logic dc, logic [2:0] ack, logic b, logic [39:0] data);
        vec_t r;
        r.p = p; r.k = k; r.m = m; r.t = t; r.v = v; r.gid = gid;
        r.gid_dc = dc; r.ack = ack; r.busy = b; r.data = data;
        return r;
    endfunction

    vec_t tbl[14];

    initial begin
        int n, acks, cyc, grants;
        logic [63:0] rnd;

        tbl[0]  = mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 3'b000, 1'b1, P_DATA);
        tbl[1]  = mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 3'b001, 1'b1, P_DATA);
        tbl[2]  = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, P_DATA);
        tbl[3]  = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'b000, 1'b1, K_DATA);
        tbl[4]  = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 3'b010, 1'b1, K_DATA);
        tbl[5]  = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, K_DATA);
        tbl[6]  = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 3'b000, 1'b1, M_DATA);
        tbl[7]  = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 3'b100, 1'b1, M_DATA);
        tbl[8]  = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, M_DATA);
        tbl[9]  = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 3'b000, 1'b1, K_DATA);
        tbl[10] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 3'b010, 1'b1, K_DATA);
        tbl[11] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, K_DATA);
        tbl[12] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 3'b000, 1'b1, M_DATA);
        tbl[13] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 3'b100, 1'b1, M_DATA);

        reset = 1'b1; power_req = 1'b0; kb_req = 1'b0; mic_req = 1'b0; out_taken = 1'b0;
        power_data = P_DATA; kb_data = K_DATA; mic_data = M_DATA;

        // Reset values
        tick(); tick();
        chk("rst_outs", 64'({out_valid, grant_id, busy, power_ack, kb_ack, mic_ack}), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_drop", 64'(drop_count), 64'(0));
        reset = 1'b0;

        // Priority and round-robin order with an always-taking sender
        for (int i = 0; i < 14; i++) begin
            power_req = tbl[i].p; kb_req = tbl[i].k; mic_req = tbl[i].m; out_taken = tbl[i].t;
            tick();
            chk("tbl_valid", 64'(out_valid), 64'(tbl[i].v));
            if (!tbl[i].gid_dc) chk("tbl_gid", 64'(grant_id), 64'(tbl[i].gid));
            chk("tbl_ack", 64'({mic_ack, kb_ack, power_ack}), 64'(tbl[i].ack));
            chk("tbl_busy", 64'(busy), 64'(tbl[i].busy));
            chk("tbl_data", 64'(out_data), 64'(tbl[i].data));
        end
        power_req = 1'b0; kb_req = 1'b0; mic_req = 1'b0; out_taken = 1'b0;
        tick();

        // Lone kb request, taken five cycles after out_valid
        kb_req = 1'b1;
        tick();
        chk("kb_valid", 64'(out_valid), 64'(1));
        chk("kb_data", 64'(out_data), 64'(K_DATA));
        chk("kb_gid", 64'(grant_id), 64'(2));
        repeat (5) tick();
        chk("kb_still_valid", 64'(out_valid), 64'(1));
        out_taken = 1'b1;
        tick();
        chk("kb_ack", 64'({mic_ack, kb_ack, power_ack}), 64'(3'b010));
        chk("kb_valid_low", 64'(out_valid), 64'(0));
        chk("kb_drop", 64'(drop_count), 64'(0));
        out_taken = 1'b0; kb_req = 1'b0;
        tick();
        chk("kb_ack_width", 64'(kb_ack), 64'(0));
        chk("kb_idle", 64'(busy), 64'(0));

        // kb and mic held together alternate strictly; kb won last, so mic first
        kb_req = 1'b1; mic_req = 1'b1; out_taken = 1'b1;
        grants = 0; cyc = 0;
        while (grants < 8 && cyc < 60) begin
            tick(); cyc++;
            if (out_valid) begin
                chk("alt_gid", 64'(grant_id), 64'((grants % 2 == 0) ? 3 : 2));
                grants++;
            end
        end
        chk("alt_count", 64'(grants), 64'(8));
        kb_req = 1'b0; mic_req = 1'b0;
        repeat (3) tick();
        out_taken = 1'b0;

        // Timeout with a stalled sender, then saturation of drop_count
        reset = 1'b1; tick(); reset = 1'b0;
        mic_req = 1'b1;
        tick();
        chk("to_valid", 64'(out_valid), 64'(1));
        n = 0;
        while (!mic_ack && n < 40) begin tick(); n++; end
        chk("to_latency", 64'(n), 64'(TO));
        chk("to_drop1", 64'(drop_count), 64'(1));
        chk("to_valid_low", 64'(out_valid), 64'(0));
        acks = 0; cyc = 0;
        while (acks < 300 && cyc < 300 * 20) begin
            tick(); cyc++;
            if (mic_ack) acks++;
        end
        chk("sat_acks", 64'(acks), 64'(300));
        chk("sat_drop", 64'(drop_count), 64'(255));
        mic_req = 1'b0;
        repeat (20) tick();

        // Take on the exact timeout cycle counts as a take
        reset = 1'b1; tick(); reset = 1'b0;
        mic_req = 1'b1;
        tick();
        repeat (TO - 1) tick();
        chk("edge_still_valid", 64'(out_valid), 64'(1));
        out_taken = 1'b1;
        tick();
        chk("edge_ack", 64'({mic_ack, kb_ack, power_ack}), 64'(3'b100));
        chk("edge_no_drop", 64'(drop_count), 64'(0));
        out_taken = 1'b0; mic_req = 1'b0;
        tick();

        // Kb take leaves rr favouring mic; reset mid-WAIT must restore rr=0
        kb_req = 1'b1; out_taken = 1'b1;
        tick(); tick();
        chk("pre_kb_ack", 64'(kb_ack), 64'(1));
        kb_req = 1'b0; out_taken = 1'b0;
        tick();
        mic_req = 1'b1;
        tick();
        chk("abort_gid", 64'(grant_id), 64'(3));
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("abort_outs", 64'({out_valid, grant_id, busy}), 64'(0));
        chk("abort_ack", 64'({mic_ack, kb_ack, power_ack}), 64'(0));
        chk("abort_drop", 64'(drop_count), 64'(0));
        reset = 1'b0; kb_req = 1'b1; mic_req = 1'b1;
        tick();
        chk("rearb_gid", 64'(grant_id), 64'(2));
        chk("rearb_valid", 64'(out_valid), 64'(1));
        kb_req = 1'b0; mic_req = 1'b0; out_taken = 1'b1;
        repeat (3) tick();

        // Randomized traffic against the model, sender behaviour varies by phase
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            power_req = ($urandom_range(0, 7) == 0);
            kb_req    = 1'($urandom_range(0, 1));
            mic_req   = 1'($urandom_range(0, 1));
            case ((c / 200) % 3)
                0:       out_taken = 1'b0;
                1:       out_taken = ($urandom_range(0, 3) == 0);
                default: out_taken = 1'b1;
            endcase
            rnd = {$urandom(), $urandom()}; power_data = rnd[39:0];
            rnd = {$urandom(), $urandom()}; kb_data    = rnd[39:0];
            rnd = {$urandom(), $urandom()}; mic_data   = rnd[39:0];
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
